// File: rtl/fp_arith_pkg.sv
// Shared types and default widths for the floating-point arithmetic datapath cells.
package fp_arith_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// Single-bit half subtractor; the borrow-side twin of the half-adder cell.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic Bo
);

    assign D  = A ^ B;
    assign Bo = ~A & B;

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B, one bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module bit_serial_subtractor
    import fp_arith_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             BORROW,
    output logic             ZERO
);

    state_t           state_r;
    state_t           state_s;

    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] d_sr_r;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;

    logic             hs_ab_d_s;
    logic             hs_ab_b_s;
    logic             hs_bin_b_s;
    logic             d_bit_s;
    logic             bout_s;
    logic             last_s;
    logic             accept_s;
    logic [WIDTH-1:0] d_shift_s;

    // Full-subtractor stage: two half subtractors plus an OR on the borrows.
    half_subtractor u_hs_ab (
        .A  (a_sr_r[0]),
        .B  (b_sr_r[0]),
        .D  (hs_ab_d_s),
        .Bo (hs_ab_b_s)
    );

    half_subtractor u_hs_bin (
        .A  (hs_ab_d_s),
        .B  (borrow_r),
        .D  (d_bit_s),
        .Bo (hs_bin_b_s)
    );

    assign bout_s    = hs_ab_b_s | hs_bin_b_s;
    assign accept_s  = in_valid & in_ready;
    assign last_s    = (cnt_r == CW'(WIDTH - 1));
    // Concatenate-then-shift keeps WIDTH=1 legal: the new bit simply becomes the result.
    assign d_shift_s = WIDTH'({d_bit_s, d_sr_r} >> 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they change with the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_s == IDLE);
            out_valid <= (state_s == DONE);
        end
    end

    // Operand/result shift registers, borrow flop, bit counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            d_sr_r   <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            D        <= '0;
            BORROW   <= 1'b0;
            ZERO     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sr_r   <= A;
                        b_sr_r   <= B;
                        d_sr_r   <= '0;
                        borrow_r <= 1'b0;
                        cnt_r    <= '0;
                    end
                end
                BUSY: begin
                    a_sr_r   <= a_sr_r >> 1'b1;
                    b_sr_r   <= b_sr_r >> 1'b1;
                    d_sr_r   <= d_shift_s;
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    // Result registers only ever see a complete difference.
                    if (last_s) begin
                        D      <= d_shift_s;
                        BORROW <= bout_s;
                        ZERO   <= ~|d_shift_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Scoreboard bench driving WIDTH=8, WIDTH=24 and WIDTH=1 instances of the serial subtractor.
module tb_bit_serial_subtractor;

    typedef struct packed {
        logic [23:0] d;
        logic        br;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] a_s [3];
    logic [23:0] b_s [3];
    logic [2:0]  iv_v;
    logic [2:0]  or_v;
    logic [2:0]  ir_v;
    logic [2:0]  ov_v;
    logic [2:0]  br_v;
    logic [2:0]  z_v;
    logic [7:0]  d8;
    logic [23:0] d24;
    logic        d1;
    logic [23:0] d_s [3];

    int check_count = 0;
    int fail_count  = 0;
    int pushed_cnt  [3] = '{0, 0, 0};
    int popped_cnt  [3] = '{0, 0, 0};
    int dropped_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    always_comb begin
        d_s[0] = {16'h0000, d8};
        d_s[1] = d24;
        d_s[2] = {23'h000000, d1};
    end

    bit_serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
        .A(a_s[0][7:0]), .B(b_s[0][7:0]), .out_valid(ov_v[0]), .out_ready(or_v[0]),
        .D(d8), .BORROW(br_v[0]), .ZERO(z_v[0])
    );

    bit_serial_subtractor #(.WIDTH(24)) u_w24 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
        .A(a_s[1]), .B(b_s[1]), .out_valid(ov_v[1]), .out_ready(or_v[1]),
        .D(d24), .BORROW(br_v[1]), .ZERO(z_v[1])
    );

    bit_serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
        .A(a_s[2][0:0]), .B(b_s[2][0:0]), .out_valid(ov_v[2]), .out_ready(or_v[2]),
        .D(d1), .BORROW(br_v[2]), .ZERO(z_v[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-instance scoreboard: push on input handshake, pop and compare on output handshake.
    for (genvar g = 0; g < 3; g++) begin : g_sb
        localparam int          W    = (g == 0) ? 8 : ((g == 1) ? 24 : 1);
        localparam logic [23:0] MASK = (W == 24) ? 24'hFFFFFF : ((24'd1 << W) - 24'd1);
        exp_t q [$];

        always @(negedge clk) begin
            logic [23:0] am;
            logic [23:0] bm;
            logic [23:0] ed;
            exp_t        e;
            if (!rst_n) begin
                dropped_cnt[g] += q.size();
                q.delete();
            end else begin
                if (iv_v[g] && ir_v[g]) begin
                    am   = a_s[g] & MASK;
                    bm   = b_s[g] & MASK;
                    ed   = (am - bm) & MASK;
                    e.d  = ed;
                    e.br = (am < bm);
                    e.z  = (ed == 24'd0);
                    q.push_back(e);
                    pushed_cnt[g]++;
                end
                if (ov_v[g] && or_v[g]) begin
                    if (q.size() == 0) begin
                        check_eq($sformatf("w%0d_unexpected_result", W), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        popped_cnt[g]++;
                        check_eq($sformatf("w%0d_D", W), d_s[g], e.d);
                        check_eq($sformatf("w%0d_BORROW", W), br_v[g], e.br);
                        check_eq($sformatf("w%0d_ZERO", W), z_v[g], e.z);
                    end
                end
            end
        end
    end

    // One directed operation; checks latency and in_ready low through BUSY and DONE.
    task automatic run_op(input int idx, input logic [23:0] a, input logic [23:0] b,
                          input int lat, input logic release_out);
        int   n;
        logic ir_seen;
        @(posedge clk); #1;
        a_s[idx]  = a;
        b_s[idx]  = b;
        iv_v[idx] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir_v[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_in_time", (n < 200), 32'd1);
        @(posedge clk); #1;
        iv_v[idx] = 1'b0;
        n       = 0;
        ir_seen = 1'b0;
        while (!ov_v[idx] && n < 200) begin
            ir_seen |= ir_v[idx];
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, lat);
        check_eq("busy_in_ready", ir_seen, 32'd0);
        check_eq("done_in_ready", ir_v[idx], 32'd0);
        if (release_out) begin
            @(posedge clk); #1;
            check_eq("post_out_valid", ov_v[idx], 32'd0);
            check_eq("post_in_ready", ir_v[idx], 32'd1);
        end
    endtask

    // Back-to-back random operands with in_valid held high; every result goes through the scoreboard.
    task automatic rand_stream(input int idx, input int nops);
        int base;
        int n;
        base      = popped_cnt[idx];
        or_v[idx] = 1'b1;
        for (int k = 0; k < nops; k++) begin
            a_s[idx]  = 24'($urandom());
            b_s[idx]  = 24'($urandom());
            iv_v[idx] = 1'b1;
            n = 0;
            @(negedge clk);
            while (!ir_v[idx] && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                check_eq("stream_accept_in_time", 32'd0, 32'd1);
            end
            @(posedge clk); #1;
        end
        iv_v[idx] = 1'b0;
        n = 0;
        while ((pushed_cnt[idx] - popped_cnt[idx] - dropped_cnt[idx]) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("stream_pending", pushed_cnt[idx] - popped_cnt[idx] - dropped_cnt[idx], 32'd0);
        check_eq("stream_count", popped_cnt[idx] - base, nops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        iv_v  = 3'b000;
        or_v  = 3'b111;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = 24'h000000;
            b_s[i] = 24'h000000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_in_ready", ir_v[i], 32'd1);
            check_eq("rst_out_valid", ov_v[i], 32'd0);
            check_eq("rst_D", d_s[i], 32'd0);
            check_eq("rst_BORROW", br_v[i], 32'd0);
            check_eq("rst_ZERO", z_v[i], 32'd0);
        end
        rst_n = 1'b1;

        run_op(0, 24'h00005A, 24'h000023, 8, 1'b1);
        run_op(0, 24'h000000, 24'h000001, 8, 1'b1);
        run_op(0, 24'h000010, 24'h0000FF, 8, 1'b1);
        run_op(1, 24'hABCDEF, 24'hABCDEF, 24, 1'b1);
        run_op(1, 24'h000000, 24'hFFFFFF, 24, 1'b1);
        run_op(2, 24'h000001, 24'h000000, 1, 1'b1);
        run_op(2, 24'h000000, 24'h000001, 1, 1'b1);

        // Result held in DONE while the consumer stalls and inputs churn.
        or_v[0] = 1'b0;
        run_op(0, 24'h000081, 24'h000080, 8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_s[0]  = 24'($urandom());
            b_s[0]  = 24'($urandom());
            iv_v[0] = ~iv_v[0];
            @(posedge clk); #1;
            check_eq("hold_D", d_s[0], 32'h01);
            check_eq("hold_BORROW", br_v[0], 32'd0);
            check_eq("hold_ZERO", z_v[0], 32'd0);
            check_eq("hold_out_valid", ov_v[0], 32'd1);
            check_eq("hold_in_ready", ir_v[0], 32'd0);
        end
        iv_v[0] = 1'b0;
        or_v[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("release_out_valid", ov_v[0], 32'd0);
        check_eq("release_in_ready", ir_v[0], 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_extra_capture", pushed_cnt[0] - popped_cnt[0] - dropped_cnt[0], 32'd0);
        check_eq("idle_out_valid", ov_v[0], 32'd0);

        // Reset pulse with the bit counter at 3.
        @(posedge clk); #1;
        a_s[0]  = 24'h0000C3;
        b_s[0]  = 24'h00003C;
        iv_v[0] = 1'b1;
        @(posedge clk); #1;
        iv_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("abort_out_valid", ov_v[0], 32'd0);
        check_eq("abort_D", d_s[0], 32'd0);
        check_eq("abort_in_ready", ir_v[0], 32'd1);
        check_eq("abort_dropped", dropped_cnt[0], 32'd1);
        run_op(0, 24'h0000C3, 24'h00003C, 8, 1'b1);

        rand_stream(2, 20);
        rand_stream(1, 12);
        rand_stream(0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
